// File: rtl/circle_raster_worker_pkg.sv
// Shared types and constants for the circle raster worker and its hit pipeline.
package Types;
    localparam int COORD_W          = 12;
    localparam int N_WORKERS        = 16;
    localparam int JOBS_SUBDIVISION = 8;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef logic [11:0] Color;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic        [COORD_W-1:0] r;
        Color                      color;
    } ColorCircle;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;

    // Halve every 4-bit channel of an RGB444 colour.
    function automatic Color rim_shade(input Color c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction
endpackage

// File: rtl/circle_hit_pipe.sv
// Two-stage pixel/circle hit test: stage 1 forms dx/dy, stage 2 compares d^2 against r^2.
// RT_WORKER_RIM_SHADE_EN adds the outer-rim flag (2*d^2 >= r^2); otherwise rim is tied low.
module circle_hit_pipe
    import Types::*;
#(
    parameter int COORD_W = Types::COORD_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      issue,
    input  logic signed [COORD_W:0]   px,
    input  logic signed [COORD_W-1:0] py,
    input  ColorCircle                circle,
    output logic                      hit,
    output logic                      rim,
    output Color                      color,
    output logic                      valid
);
    localparam int DW  = COORD_W + 2;
    localparam int SQW = 2 * COORD_W + 5;
    localparam int RW  = 2 * COORD_W;

    logic signed [DW-1:0]      dx_q, dy_q;
    logic        [COORD_W-1:0] r_q;
    Color                      col_q;
    logic                      v1_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dx_q  <= '0;
            dy_q  <= '0;
            r_q   <= '0;
            col_q <= '0;
            v1_q  <= LOW;
        end else begin
            v1_q <= issue;
            if (issue) begin
                dx_q  <= DW'(px) - DW'($signed(circle.x));
                dy_q  <= DW'(py) - DW'($signed(circle.y));
                r_q   <= circle.r;
                col_q <= circle.color;
            end
        end
    end

    logic signed [SQW-1:0] dx_sq, dy_sq;
    logic        [SQW-1:0] d2;
    logic        [RW-1:0]  r2;
    logic                  hit_d, rim_d;

    assign dx_sq = SQW'(dx_q) * SQW'(dx_q);
    assign dy_sq = SQW'(dy_q) * SQW'(dy_q);
    assign d2    = dx_sq + dy_sq;
    assign r2    = RW'(r_q) * RW'(r_q);
    // Strict compare, so r=0 can never hit.
    assign hit_d = v1_q && (d2 < SQW'(r2));
`ifdef RT_WORKER_RIM_SHADE_EN
    assign rim_d = ({d2, 1'b0} >= (SQW+1)'(r2));
`else
    assign rim_d = LOW;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit   <= LOW;
            rim   <= LOW;
            color <= '0;
            valid <= LOW;
        end else begin
            hit   <= hit_d;
            rim   <= rim_d;
            color <= col_q;
            valid <= v1_q;
        end
    end
endmodule

// File: rtl/circle_raster_worker.sv
// Shades one scanline job of JOBS_SUBDIVISION pixels against a snapshot of N_CIRCLES circles,
// painter's order (highest index wins). Rim shading is enabled by RT_WORKER_RIM_SHADE_EN.
module circle_raster_worker
    import Types::*;
#(
    parameter int   N_CIRCLES        = 4,
    parameter int   JOBS_SUBDIVISION = Types::JOBS_SUBDIVISION,
    parameter int   N_WORKERS        = Types::N_WORKERS,
    parameter int   COORD_W          = Types::COORD_W,
    parameter Color BG_COLOR         = 12'h000
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                abort,
    input  logic signed [COORD_W-1:0]           x,
    input  logic signed [COORD_W-1:0]           y,
    input  ColorCircle [N_CIRCLES-1:0]          circles,
    output logic                                busy,
    output logic                                done,
    output Color [JOBS_SUBDIVISION-1:0]         buffer
);
    localparam int KW = (N_CIRCLES > 1)        ? $clog2(N_CIRCLES)        : 1;
    localparam int JW = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

    state_t                    state_q, state_d;
    logic signed [COORD_W-1:0] x_q, y_q;
    ColorCircle [N_CIRCLES-1:0] snap_q;
    logic [KW-1:0]             k_q;
    logic [JW-1:0]             j_q;
    logic                      dcnt_q;
    Color                      best_q, best_nxt, hit_col;

    logic                      last_k, last_j;
    logic signed [COORD_W:0]   px;
    logic                      p_hit, p_rim, p_valid;
    Color                      p_color;

    assign last_k = (k_q == KW'(N_CIRCLES - 1));
    assign last_j = (j_q == JW'(JOBS_SUBDIVISION - 1));
    // One bit wider than x so the stride offset never wraps.
    assign px     = (COORD_W+1)'(x_q) + (COORD_W+1)'(int'(j_q) * N_WORKERS);

    circle_hit_pipe #(.COORD_W(COORD_W)) u_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .issue  (state_q == SCAN),
        .px     (px),
        .py     (y_q),
        .circle (snap_q[k_q]),
        .hit    (p_hit),
        .rim    (p_rim),
        .color  (p_color),
        .valid  (p_valid)
    );

    assign hit_col  = p_rim ? rim_shade(p_color) : p_color;
    assign best_nxt = (p_valid && p_hit) ? hit_col : best_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE) ? HIGH : LOW;
        done    = (state_q == DONE) ? HIGH : LOW;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SCAN;
            SCAN:    if (last_k) state_d = DRAIN;
            DRAIN:   if (dcnt_q) state_d = last_j ? DONE : SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q    <= '0;
            y_q    <= '0;
            snap_q <= '0;
            k_q    <= '0;
            j_q    <= '0;
            dcnt_q <= LOW;
            best_q <= BG_COLOR;
            buffer <= {JOBS_SUBDIVISION{BG_COLOR}};
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    x_q    <= x;
                    y_q    <= y;
                    snap_q <= circles;
                end
                LOAD: begin
                    j_q    <= '0;
                    k_q    <= '0;
                    dcnt_q <= LOW;
                    best_q <= BG_COLOR;
                end
                SCAN: begin
                    k_q    <= k_q + 1'b1;
                    best_q <= best_nxt;
                end
                DRAIN: begin
                    best_q <= best_nxt;
                    dcnt_q <= ~dcnt_q;
                    // The last circle's result lands this cycle, so commit best_nxt.
                    if (dcnt_q && !abort) begin
                        buffer[j_q] <= best_nxt;
                        j_q         <= j_q + 1'b1;
                        k_q         <= '0;
                        best_q      <= BG_COLOR;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_circle_raster_worker.sv
// Self-checking bench: directed vector table, hand-written abort/reset/handshake sequences,
// and randomized jobs checked against an arithmetic reference model.
module tb_circle_raster_worker;
    import Types::*;

    localparam int NC  = 4;
    localparam int NJ  = 8;
    localparam int NW  = 16;
    localparam int LAT = 2 + NJ * (NC + 2);
`ifdef RT_WORKER_RIM_SHADE_EN
    localparam bit RIM_EN = 1'b1;
`else
    localparam bit RIM_EN = 1'b0;
`endif

    typedef Color [NJ-1:0]       buf_t;
    typedef ColorCircle [NC-1:0] cset_t;

    typedef struct {
        string name;
        int    x;
        int    y;
        cset_t c;
        buf_t  exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic signed [11:0]  x = '0;
    logic signed [11:0]  y = '0;
    cset_t               circles = '0;
    logic                busy, done;
    buf_t                buffer;

    int checks = 0;
    int errors = 0;

    circle_raster_worker #(
        .N_CIRCLES(NC), .JOBS_SUBDIVISION(NJ), .N_WORKERS(NW),
        .COORD_W(12), .BG_COLOR(12'h000)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .x(x), .y(y), .circles(circles),
        .busy(busy), .done(done), .buffer(buffer)
    );

    always #5 clk = ~clk;

    function automatic ColorCircle mk(input int cx, input int cy, input int r, input int col);
        ColorCircle c;
        c.x     = 12'(cx);
        c.y     = 12'(cy);
        c.r     = 12'(r);
        c.color = 12'(col);
        return c;
    endfunction

    // Reference: plain integer geometry, last hitting circle wins.
    function automatic Color model_pix(input int px, input int py, input cset_t c);
        int res = 0;
        for (int k = 0; k < NC; k++) begin
            int     cx = int'($signed(c[k].x));
            int     cy = int'($signed(c[k].y));
            longint rr = longint'(c[k].r);
            longint dx = longint'(px - cx);
            longint dy = longint'(py - cy);
            longint d2 = dx * dx + dy * dy;
            if (d2 < rr * rr) begin
                int col = int'(c[k].color);
                if (RIM_EN && 2 * d2 >= rr * rr)
                    col = ((col / 256) / 2) * 256 + (((col / 16) % 16) / 2) * 16 + (col % 16) / 2;
                res = col;
            end
        end
        return 12'(res);
    endfunction

    function automatic buf_t model_buf(input int jx, input int jy, input cset_t c);
        buf_t b;
        for (int j = 0; j < NJ; j++) b[j] = model_pix(jx + j * NW, jy, c);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_job(input int jx, input int jy, input cset_t jc, input bit ab,
                           input int poke, output int lat);
        x = 12'(jx); y = 12'(jy); circles = jc; start = 1'b1; abort = ab;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        x = 12'($urandom); y = 12'($urandom);
        circles = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == 1) chk("busy_rise", busy, 1'b1);
            start = (poke != 0 && n == poke);
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic do_job(input string nm, input int jx, input int jy, input cset_t jc,
                          input bit ab, input int poke, input buf_t exp);
        int lat;
        run_job(jx, jy, jc, ab, poke, lat);
        chk({nm, "_lat"}, lat, LAT);
        chk({nm, "_buf"}, buffer, exp);
        @(negedge clk);
        chk({nm, "_busy_fall"}, {busy, done}, 2'b00);
    endtask

    function automatic ColorCircle rand_circle();
        if ($urandom_range(0, 3) == 0)
            return mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        return mk(int'($urandom_range(0, 200)) - 60, int'($urandom_range(0, 80)) - 40,
                  int'($urandom_range(0, 60)), int'($urandom));
    endfunction

    vec_t  vecs[7];
    cset_t c;
    buf_t  e, prev;

    initial begin
        // Directed vectors.
        c = '0; c[0] = mk(0, 0, 5, 12'hF00);
        vecs[0] = '{"miss_edge", 3, 4, c, '0};
        e = '0; e[0] = RIM_EN ? 12'h700 : 12'hF00;
        vecs[1] = '{"hit_inner", 3, 3, c, e};
        c = '0; c[0] = mk(10, 10, 8, 12'h0F0); c[1] = mk(12, 10, 8, 12'h00F);
        e = '0; e[0] = 12'h00F;
        vecs[2] = '{"overlap", 11, 10, c, e};
        c = '0; c[0] = mk(12, 10, 8, 12'h00F); c[1] = mk(10, 10, 8, 12'h0F0);
        e = '0; e[0] = 12'h0F0;
        vecs[3] = '{"overlap_swap", 11, 10, c, e};
        c = '0; c[0] = mk(0, 0, 1, 12'hFFF);
        e = '0; e[1] = 12'hFFF;
        vecs[4] = '{"stride_neg", -16, 0, c, e};
        c = '0; c[2] = mk(-20, -5, 6, 12'hABC);
        e = '0; e[0] = 12'hABC;
        vecs[5] = '{"neg_coords", -22, -3, c, e};
        c = '0; c[3] = mk(2047, 0, 100, 12'h5A5);
        e = {7{12'h5A5}}; e[7] = 12'h000;
        if (RIM_EN) begin e[5] = 12'h252; e[6] = 12'h252; end
        vecs[6] = '{"no_wrap", 2040, 0, c, e};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_buf", buffer, '0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_job(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, 0, vecs[i].exp);

        // Asynchronous reset in the middle of a scan.
        x = 12'(-16); y = '0; circles = vecs[4].c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_buf", buffer, '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Start while busy is ignored; start with abort in idle is accepted.
        do_job("busy_start", vecs[1].x, vecs[1].y, vecs[1].c, 1'b0, 10, vecs[1].exp);
        do_job("abort_idle", vecs[2].x, vecs[2].y, vecs[2].c, 1'b1, 0, vecs[2].exp);
        prev = vecs[2].exp;

        // Abort during pixel 2: pixels 0-1 written, the rest untouched.
        c = '0; c[0] = mk(0, 0, 4000, 12'h123);
        x = '0; y = '0; circles = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        e = prev; e[0] = 12'h123; e[1] = 12'h123;
        chk("abort_buf", buffer, e);
        c = '0; c[1] = mk(30, 2, 20, 12'h9C3); c[3] = mk(50, 0, 9, 12'h00E);
        do_job("after_abort", 20, 1, c, 1'b0, 0, model_buf(20, 1, c));

`ifdef RT_WORKER_RIM_SHADE_EN
        c = '0; c[0] = mk(0, 0, 10, 12'hF00);
        e = '0; e[0] = 12'h700;
        do_job("rim_outer", 8, 0, c, 1'b0, 0, e);
        e = '0; e[0] = 12'hF00;
        do_job("rim_inner", 5, 0, c, 1'b0, 0, e);
`endif

        // Randomized jobs against the reference model.
        for (int t = 0; t < 25; t++) begin
            logic signed [11:0] rx, ry;
            int jx, jy;
            for (int k = 0; k < NC; k++) c[k] = rand_circle();
            if ($urandom_range(0, 3) == 0) begin
                rx = 12'($urandom); ry = 12'($urandom);
            end else begin
                rx = 12'(int'($urandom_range(0, 120)) - 60);
                ry = 12'(int'($urandom_range(0, 60)) - 30);
            end
            jx = int'(rx); jy = int'(ry);
            do_job("random", jx, jy, c, 1'b0, 0, model_buf(jx, jy, c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
